// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and opcode decode for the sequential shift unit.
// Optional macro ALU_SHIFT_ROTATE_EN adds ROR to the set of legal shift opcodes.
package alu_pkg;

  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;
  localparam logic [4:0] OP_SRL = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  function automatic logic is_shift_op(input logic [4:0] opcode);
    logic legal;
    legal = (opcode == OP_SLL) || (opcode == OP_SRA) || (opcode == OP_SRL);
`ifdef ALU_SHIFT_ROTATE_EN
    legal = legal || (opcode == OP_ROR);
`endif
    return legal;
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One combinational shift step of k_i (0..STEP) positions; a mux of constant shifts, not a barrel.
// ROR decode exists only when ALU_SHIFT_ROTATE_EN is defined.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4,
  parameter int unsigned AMTW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [4:0]       opcode_i,
  input  logic [AMTW:0]    k_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    for (int j = 1; j <= int'(STEP); j++) begin
      if (k_i == (AMTW+1)'(j)) begin
        case (opcode_i)
          OP_SLL:  data_o = data_i << j;
          OP_SRL:  data_o = data_i >> j;
          // MSB is preserved by every SRA step, so it is always the original sign bit.
          OP_SRA:  data_o = WIDTH'($signed(data_i) >>> j);
`ifdef ALU_SHIFT_ROTATE_EN
          OP_ROR:  data_o = (data_i >> j) | (data_i << (int'(WIDTH) - j));
`endif
          default: data_o = data_i;
        endcase
      end
    end
  end

endmodule

// File: rtl/alu_seq_shifter.sv
// Multi-cycle shift unit (SLL/SRA/SRL, optional ROR via ALU_SHIFT_ROTATE_EN) with valid/ready
// handshakes; shifts at most STEP positions per clock.
module alu_seq_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4,
  parameter int unsigned AMTW  = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       ctrl_ALUopcode,
  input  logic [AMTW-1:0]  ctrl_shiftamt,
  input  logic [WIDTH-1:0] data_operandA,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             op_illegal,
  output logic             busy
);

  localparam logic [AMTW:0] StepK = (AMTW+1)'(STEP);

  state_e           state_q;
  logic [4:0]       opcode_q;
  logic [AMTW-1:0]  rem_q;
  logic [WIDTH-1:0] data_q;
  logic             illegal_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             busy_q;

  logic [AMTW:0]    rem_ext;
  logic [AMTW:0]    k;
  logic [AMTW-1:0]  rem_next;
  logic [WIDTH-1:0] step_data;
  logic             accept_illegal;

  always_comb begin
    rem_ext        = {1'b0, rem_q};
    k              = (rem_ext > StepK) ? StepK : rem_ext;
    rem_next       = AMTW'(rem_ext - k);
    accept_illegal = !is_shift_op(ctrl_ALUopcode);
  end

  alu_shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AMTW  (AMTW)
  ) u_step (
    .data_i   (data_q),
    .opcode_i (opcode_q),
    .k_i      (k),
    .data_o   (step_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      opcode_q    <= '0;
      rem_q       <= '0;
      data_q      <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q     <= data_operandA;
            opcode_q   <= ctrl_ALUopcode;
            rem_q      <= ctrl_shiftamt;
            illegal_q  <= accept_illegal;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (accept_illegal || (ctrl_shiftamt == '0)) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_q <= step_data;
          rem_q  <= rem_next;
          if (rem_next == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign data_result = data_q;
  assign op_illegal  = illegal_q;

endmodule

// File: tb/tb_alu_seq_shifter.sv
// Self-checking bench for alu_seq_shifter (WIDTH=32, STEP=4): directed cases then random ops
// checked against a plain-arithmetic reference model.
module tb_alu_seq_shifter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned STEP  = 4;
  localparam int unsigned AMTW  = 5;

  logic             clock;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       ctrl_ALUopcode;
  logic [AMTW-1:0]  ctrl_shiftamt;
  logic [WIDTH-1:0] data_operandA;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_result;
  logic             op_illegal;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq_shifter #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .ctrl_ALUopcode (ctrl_ALUopcode),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_operandA  (data_operandA),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .data_result    (data_result),
    .op_illegal     (op_illegal),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bit ref_legal(input logic [4:0] op);
    bit legal;
    legal = (op == 5'b00100) || (op == 5'b00101) || (op == 5'b00110);
`ifdef ALU_SHIFT_ROTATE_EN
    legal = legal || (op == 5'b00111);
`endif
    return legal;
  endfunction

  function automatic logic [31:0] ref_result(input logic [4:0] op, input int amt,
                                             input logic [31:0] a);
    logic signed [31:0] s;
    logic [63:0]        dbl;
    s   = a;
    dbl = {a, a};
    if (!ref_legal(op)) return a;
    case (op)
      5'b00100: return a << amt;
      5'b00110: return a >> amt;
      5'b00101: return 32'(s >>> amt);
      default:  return dbl[31:0] >> amt | (dbl[63:32] << (32 - amt)) & ((amt == 0) ? 32'h0 : 32'hFFFF_FFFF);
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input int amt);
    if (!ref_legal(op)) return 1;
    return 1 + (amt + int'(STEP) - 1) / int'(STEP);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Counts edges from the accept edge (edge 1) until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic do_op(input logic [4:0] op, input int amt, input logic [31:0] a,
                       input int hold, input string tag);
    int          lat;
    logic [31:0] exp;
    exp = ref_result(op, amt, a);
    @(negedge clock);
    in_valid       = 1'b1;
    ctrl_ALUopcode = op;
    ctrl_shiftamt  = AMTW'(amt);
    data_operandA  = a;
    out_ready      = 1'b0;
    chk({tag, " in_ready_before"}, 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk({tag, " busy_after_accept"}, 32'(busy), 32'd1);
    wait_done(lat);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(ref_latency(op, amt)));
    chk({tag, " result"}, data_result, exp);
    chk({tag, " op_illegal"}, 32'(op_illegal), 32'(!ref_legal(op)));
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      chk({tag, " hold_result"}, data_result, exp);
      chk({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk({tag, " in_ready_after"}, 32'(in_ready), 32'd1);
    chk({tag, " out_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int          lat;
    logic [4:0]  rop;
    int          ramt;
    logic [31:0] ra;
    logic [4:0]  op_table [5];

    reset_n        = 1'b0;
    in_valid       = 1'b0;
    out_ready      = 1'b0;
    ctrl_ALUopcode = '0;
    ctrl_shiftamt  = '0;
    data_operandA  = '0;
    #3;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset data_result", data_result, 32'd0);
    chk("reset op_illegal", 32'(op_illegal), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    #10;
    reset_n = 1'b1;
    @(negedge clock);
    chk("reset in_ready", 32'(in_ready), 32'd1);

    do_op(5'b00101, 31, 32'h8000_0000, 0, "sra_sign");
    do_op(5'b00100, 0, 32'h0000_0001, 0, "sll_amt0");
    do_op(5'b00110, 4, 32'hF000_0000, 5, "srl_hold");
    do_op(5'b00000, 7, 32'h1234_ABCD, 1, "illegal");
    do_op(5'b00111, 1, 32'h0000_0001, 0, "ror");
    do_op(5'b00100, 31, 32'h0000_0001, 0, "sll_max");
    do_op(5'b00110, 5, 32'h8765_4321, 0, "srl_odd");

    // Second request held while busy must wait for IDLE.
    @(negedge clock);
    in_valid       = 1'b1;
    ctrl_ALUopcode = 5'b00100;
    ctrl_shiftamt  = 5'd8;
    data_operandA  = 32'h0000_0003;
    @(posedge clock);
    #1;
    ctrl_ALUopcode = 5'b00110;
    ctrl_shiftamt  = 5'd4;
    data_operandA  = 32'hA000_0000;
    chk("busy in_ready", 32'(in_ready), 32'd0);
    wait_done(lat);
    chk("busy first_latency", 32'(lat), 32'd3);
    chk("busy first_result", data_result, 32'h0000_0300);
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk("busy idle_again", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk("busy second_accept", 32'(busy), 32'd1);
    wait_done(lat);
    chk("busy second_latency", 32'(lat), 32'd2);
    chk("busy second_result", data_result, 32'h0A00_0000);
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a shift.
    @(negedge clock);
    in_valid       = 1'b1;
    ctrl_ALUopcode = 5'b00101;
    ctrl_shiftamt  = 5'd31;
    data_operandA  = 32'h8000_0000;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset data_result", data_result, 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    do_op(5'b00100, 4, 32'h0000_00F1, 0, "after_reset");

    op_table[0] = 5'b00100;
    op_table[1] = 5'b00101;
    op_table[2] = 5'b00110;
    op_table[3] = 5'b00111;
    for (int n = 0; n < 40; n++) begin
      op_table[4] = 5'($urandom_range(0, 31));
      rop  = op_table[$urandom_range(0, 4)];
      ramt = int'($urandom_range(0, 31));
      ra   = $urandom;
      do_op(rop, ramt, ra, int'($urandom_range(0, 2)), "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
